// File: rtl/ema_update_if.sv
// Sample/alpha/result bundle between the EMA update stage and its neighbours.
// master drives samples and alpha; slave is the EMA stage itself.
interface ema_update_if #(
    parameter int W_X = 8,
    parameter int W_A = 8
);
    logic        [W_A-1:0] alpha_i;
    logic                  alpha_valid_i;
    logic signed [W_X-1:0] x_i;
    logic                  valid_i;
    logic signed [W_X-1:0] y_o;
    logic                  valid_o;
    logic                  busy_o;

    modport master (
        output alpha_i, alpha_valid_i, x_i, valid_i,
        input  y_o, valid_o, busy_o
    );

    modport slave (
        input  alpha_i, alpha_valid_i, x_i, valid_i,
        output y_o, valid_o, busy_o
    );
endinterface

// File: rtl/ema_update_unit.sv
// Exponential moving average: acc += alpha*(x - acc), alpha = 1/N from the inverter.
// The multiply is sequential shift-add, one alpha bit per cycle; acc is Q(W_X).W_A.
module ema_update_unit #(
    parameter int W_X = 8,
    parameter int W_A = 8
) (
    input  logic         clk,
    input  logic         rst,
    ema_update_if.slave  bus
);
    localparam int ACC_W = W_X + W_A;
    localparam int D_W   = ACC_W + 1;
    localparam int P_W   = W_X + 2 * W_A + 1;
    localparam int K_W   = (W_A > 1) ? $clog2(W_A) : 1;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (W_A - 1));

    typedef enum logic [2:0] {IDLE, INIT, DIFF, MUL, UPDATE, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [D_W-1:0]   diff_q, diff_d;
    logic signed [P_W-1:0]   prod_q, prod_d;
    logic        [K_W-1:0]   k_q, k_d;
    logic signed [W_X-1:0]   x_q, x_d;
    logic signed [W_X-1:0]   y_q, y_d;
    logic        [W_A-1:0]   alpha_r_q, alpha_r_d;
    logic        [W_A-1:0]   alpha_w_q, alpha_w_d;
    logic                    init_q, init_d;

    // Round half up from Q.W_A back to a W_X sample; no saturation since acc
    // is always a convex combination of past samples.
    function automatic logic signed [W_X-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
        return W_X'((a + HALF) >>> W_A);
    endfunction

    function automatic logic signed [ACC_W-1:0] floor_scale(input logic signed [P_W-1:0] p);
        return ACC_W'(p >>> W_A);
    endfunction

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        diff_d    = diff_q;
        prod_d    = prod_q;
        k_d       = k_q;
        x_d       = x_q;
        y_d       = y_q;
        alpha_w_d = alpha_w_q;
        init_d    = init_q;
        alpha_r_d = bus.alpha_valid_i ? bus.alpha_i : alpha_r_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    x_d       = bus.x_i;
                    alpha_w_d = bus.alpha_valid_i ? bus.alpha_i : alpha_r_q;
                    state_d   = init_q ? DIFF : INIT;
                end
            end
            INIT: begin
                acc_d   = {x_q, {W_A{1'b0}}};
                init_d  = 1'b1;
                y_d     = round_half_up(acc_d);
                state_d = DONE;
            end
            DIFF: begin
                diff_d  = {x_q[W_X-1], x_q, {W_A{1'b0}}} - {acc_q[ACC_W-1], acc_q};
                prod_d  = '0;
                k_d     = '0;
                state_d = MUL;
            end
            MUL: begin
                // Sign-extended difference weighted by alpha bit k.
                if (alpha_w_q[k_q]) begin
                    prod_d = prod_q + ({{W_A{diff_q[D_W-1]}}, diff_q} << k_q);
                end
                k_d = k_q + K_W'(1);
                if (k_q == K_W'(W_A - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // y is registered on entry to DONE so it is valid alongside valid_o.
                acc_d   = acc_q + floor_scale(prod_q);
                y_d     = round_half_up(acc_d);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            diff_q    <= '0;
            prod_q    <= '0;
            k_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            alpha_r_q <= '0;
            alpha_w_q <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            diff_q    <= diff_d;
            prod_q    <= prod_d;
            k_q       <= k_d;
            x_q       <= x_d;
            y_q       <= y_d;
            alpha_r_q <= alpha_r_d;
            alpha_w_q <= alpha_w_d;
            init_q    <= init_d;
        end
    end

    assign bus.y_o     = y_q;
    assign bus.valid_o = (state_q == DONE);
    assign bus.busy_o  = (state_q != IDLE);
endmodule

// File: tb/tb_ema_update_unit.sv
// Directed bench for ema_update_unit with an arithmetic reference model and
// per-cycle comparison of valid_o, busy_o and y_o, plus literal expectations.
module tb_ema_update_unit;
    localparam int W_X = 8;
    localparam int W_A = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    ema_update_if #(.W_X(W_X), .W_A(W_A)) bus ();

    ema_update_unit #(.W_X(W_X), .W_A(W_A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: whole-sample arithmetic, timing from the latency rules.
    int     medge      = 0;
    int     busy_until = -10;
    int     vedge      = -10;
    bit     pend       = 1'b0;
    bit     m_init     = 1'b0;
    longint m_acc      = 0;
    int     m_y        = 0;
    int     pend_y     = 0;
    int     m_alpha    = 0;

    always @(posedge clk or posedge rst) begin
        int     aw;
        int     lat;
        longint xs;
        if (rst) begin
            busy_until = -10;
            vedge      = -10;
            pend       = 1'b0;
            m_init     = 1'b0;
            m_acc      = 0;
            m_y        = 0;
            m_alpha    = 0;
        end else begin
            medge++;
            if (pend && medge == vedge) begin
                m_y  = pend_y;
                pend = 1'b0;
            end
            if (bus.valid_i === 1'b1 && medge >= busy_until + 2) begin
                aw = bus.alpha_valid_i ? int'(bus.alpha_i) : m_alpha;
                xs = longint'(bus.x_i) * 256;
                if (!m_init) begin
                    m_acc  = xs;
                    m_init = 1'b1;
                    lat    = 1;
                end else begin
                    m_acc = m_acc + ((longint'(aw) * (xs - m_acc)) >>> 8);
                    lat   = W_A + 2;
                end
                pend_y     = int'((m_acc + 128) >>> 8);
                pend       = 1'b1;
                busy_until = medge + lat;
                vedge      = busy_until;
            end
            if (bus.alpha_valid_i === 1'b1) m_alpha = int'(bus.alpha_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.valid_o !== (medge == vedge)) begin
                errors++;
                $display("FAIL model valid_o at edge %0d: got %b, expected %b", medge, bus.valid_o, (medge == vedge));
            end
            checks++;
            if (bus.busy_o !== (medge <= busy_until)) begin
                errors++;
                $display("FAIL model busy_o at edge %0d: got %b, expected %b", medge, bus.busy_o, (medge <= busy_until));
            end
            checks++;
            if ($isunknown(bus.y_o) || int'(bus.y_o) != m_y) begin
                errors++;
                $display("FAIL model y_o at edge %0d: got %0d, expected %0d", medge, bus.y_o, m_y);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic start(input int x, input bit av, input int a);
        @(posedge clk); #2;
        bus.valid_i       = 1'b1;
        bus.x_i           = x[W_X-1:0];
        bus.alpha_valid_i = av;
        bus.alpha_i       = a[W_A-1:0];
        @(posedge clk); #2;
        bus.valid_i       = 1'b0;
        bus.alpha_valid_i = 1'b0;
    endtask

    // Issue one sample and wait for its result; optionally pokes valid_i and a
    // new alpha while the multiply is running.
    task automatic send(input int x, input bit av, input int a, input int want_y,
                        input int want_cyc, input string nm, input bit poke = 1'b0);
        int lat;
        bit seen;
        start(x, av, a);
        lat  = 0;
        seen = 1'b0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            if (lat == 0) chk({nm, " busy after accept"}, int'(bus.busy_o), 1);
            if (bus.valid_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                lat++;
                if (poke && lat == 4) begin
                    #2;
                    bus.valid_i       = 1'b1;
                    bus.x_i           = -8'sd50;
                    bus.alpha_valid_i = 1'b1;
                    bus.alpha_i       = 8'h80;
                end
                if (poke && lat == 5) begin
                    #2;
                    bus.valid_i       = 1'b0;
                    bus.alpha_valid_i = 1'b0;
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no valid_o within 40 cycles, expected cycle %0d", nm, want_cyc);
        end else begin
            chk({nm, " y_o"}, int'(bus.y_o), want_y);
            chk({nm, " valid_o cycle"}, lat + 1, want_cyc);
        end
    endtask

    initial begin
        bus.valid_i       = 1'b0;
        bus.x_i           = '0;
        bus.alpha_valid_i = 1'b0;
        bus.alpha_i       = '0;
        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset y_o", int'(bus.y_o), 0);
        chk("reset valid_o", int'(bus.valid_o), 0);
        chk("reset busy_o", int'(bus.busy_o), 0);

        // First sample passes straight through.
        send(100, 1'b0, 0, 100, 2, "t1 first");

        // alpha = 1/2.
        do_reset();
        send(0, 1'b1, 'h80, 0, 2, "t2 first");
        send(100, 1'b0, 0, 50, 11, "t2 second");
        send(100, 1'b0, 0, 75, 11, "t2 third");

        // alpha = 1/4 loaded in the same cycle as the sample; extremes of x.
        do_reset();
        send(-128, 1'b0, 0, -128, 2, "t3 first");
        send(127, 1'b1, 'h40, -64, 11, "t3 second");
        send(127, 1'b0, 0, -16, 11, "t3 third");

        // Strobe and alpha change during the multiply: old alpha for this result.
        send(127, 1'b0, 0, 19, 11, "t4 poked", 1'b1);
        send(127, 1'b0, 0, 73, 11, "t4 new alpha");

        // alpha = 0 leaves the average unchanged.
        do_reset();
        send(50, 1'b0, 0, 50, 2, "t5 first");
        send(-100, 1'b1, 0, 50, 11, "t5 alpha0");

        // Reset mid-multiply aborts the sample; next one is a first sample.
        do_reset();
        send(0, 1'b1, 'h80, 0, 2, "t6 first");
        start(100, 1'b0, 0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 rst y_o", int'(bus.y_o), 0);
        chk("t6 rst valid_o", int'(bus.valid_o), 0);
        chk("t6 rst busy_o", int'(bus.busy_o), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        send(20, 1'b0, 0, 20, 2, "t6 after reset");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
